uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that responds to CPU load/store accesses on the data bus and serialises bytes onto a single `tx` line. It is the output end of the CPU: stores to its TXDATA register are queued and shifted out as 8N1 frames, and loads return status. It sits beside data memory in the CPU top level, selected by the address decoder.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_fifo.sv | 65 ++++++
 rtl/uart_tx_mmio.sv | 197 +++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared register offsets, STATUS bit indices and shifter states
//
// Purpose: constants and types shared by the UART transmitter files.
// Ports:   none (package).
package uart_pkg;

  // Byte offsets within the peripheral window
  localparam logic [3:0] UART_TXDATA  = 4'h0;
  localparam logic [3:0] UART_STATUS  = 4'h4;
  localparam logic [3:0] UART_BAUDDIV = 4'h8;

  // STATUS register bit positions
  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;
  localparam int STAT_EMPTY = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte queue feeding the UART shifter
//
// Purpose: synchronous FIFO with push/pop, full/empty. A push into a full
//          queue is accepted when a pop happens in the same cycle; the byte
//          lands at the tail and the count stays full.
// Ports:   clk_i, rst_ni (async active-low), push_i, pop_i, wdata_i[7:0],
//          head_o[7:0] (current head, valid when not empty), full_o, empty_o.
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] wdata_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter
//
// Purpose: CPU stores to TXDATA queue bytes that are shifted out LSB first
//          as 8N1 frames; loads return STATUS/BAUDDIV.
// Ports:   clk, rst (async active-low), sel, we, addr[3:0], wdata[31:0],
//          rdata[31:0] (combinational, 0 when not selected), tx (idle high),
//          irq (queue empty and shifter idle).
// Config:  UART_TX_FIFO_EN selects a FIFO_DEPTH-entry queue; otherwise a
//          single holding register is used.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int unsigned DEFAULT_DIV = 434,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);

  localparam logic [15:0] DIV_RST = 16'(DEFAULT_DIV);

  logic wr_txdata, wr_status, wr_baud;
  assign wr_txdata = sel && we && (addr == UART_TXDATA);
  assign wr_status = sel && we && (addr == UART_STATUS);
  assign wr_baud   = sel && we && (addr == UART_BAUDDIV);

  logic unused_wdata;
  assign unused_wdata = ^wdata[31:16];

  uart_state_e state_q, state_d;
  logic [15:0] baud_q, baud_d;    // programmed divider
  logic [15:0] div_q, div_d;      // divider in force for the current bit
  logic [15:0] timer_q, timer_d;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_q, bit_d;
  logic        ovf_q, ovf_d;
  logic        q_full, q_empty, pop;
  logic [7:0]  q_head;
  logic        bit_end, busy;

  assign busy    = (state_q != ST_IDLE);
  assign bit_end = busy && (timer_q == div_q - 16'd1);

`ifdef UART_TX_FIFO_EN
  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (wr_txdata),
    .pop_i   (pop),
    .wdata_i (wdata[7:0]),
    .head_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );
`else
  logic       hold_vld_q, hold_vld_d;
  logic [7:0] hold_q, hold_d;

  // A store while the register is occupied is still taken if the shifter
  // empties it on the same edge.
  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    if (pop) hold_vld_d = 1'b0;
    if (wr_txdata && (!hold_vld_q || pop)) begin
      hold_d     = wdata[7:0];
      hold_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_vld_q <= 1'b0;
      hold_q     <= 8'h00;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
    end
  end

  assign q_head  = hold_q;
  assign q_full  = hold_vld_q;
  assign q_empty = !hold_vld_q;
`endif

  // Register writes
  always_comb begin
    baud_d = baud_q;
    ovf_d  = ovf_q;
    if (wr_baud) baud_d = (wdata[15:0] == 16'd0) ? 16'd1 : wdata[15:0];
    if (wr_status && wdata[STAT_OVF]) ovf_d = 1'b0;
    if (wr_txdata && q_full && !pop) ovf_d = 1'b1;
  end

  // Shifter FSM. The divider is resampled only at bit boundaries so a
  // BAUDDIV change never stretches or truncates the bit in flight. A
  // pending byte is popped straight out of STOP so frames run back to back.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    div_d   = div_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    pop     = 1'b0;
    if (busy) timer_d = bit_end ? 16'd0 : timer_q + 16'd1;
    if (bit_end) div_d = baud_q;
    case (state_q)
      ST_IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          shift_d = q_head;
          bit_d   = 3'd0;
          timer_d = 16'd0;
          div_d   = baud_q;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (!q_empty) begin
            pop     = 1'b1;
            shift_d = q_head;
            bit_d   = 3'd0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      baud_q  <= DIV_RST;
      div_q   <= DIV_RST;
      timer_q <= 16'd0;
      shift_q <= 8'h00;
      bit_q   <= 3'd0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      div_q   <= div_d;
      timer_q <= timer_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    case (state_q)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = shift_q[0];
      default:  tx = 1'b1;
    endcase
  end

  assign irq = q_empty && (state_q == ST_IDLE);

  always_comb begin
    rdata = 32'h0;
    if (sel) begin
      case (addr)
        UART_STATUS: begin
          rdata[STAT_BUSY]  = busy;
          rdata[STAT_FULL]  = q_full;
          rdata[STAT_OVF]   = ovf_q;
          rdata[STAT_EMPTY] = q_empty;
        end
        UART_BAUDDIV: rdata[15:0] = baud_q;
        default: rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio
module tb_uart_tx_mmio;
  import uart_pkg::*;

`ifdef UART_TX_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic        tx, irq;

  uart_tx_mmio #(.DEFAULT_DIV(434), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Inputs are driven 1ns after a rising edge
  task automatic store(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; addr = a;
    #1 d = rdata;
    sel = 1'b0;
  endtask

  // Cycle counter and serial receiver: samples each bit in its middle
  int         cyc = 0;
  always @(posedge clk) cyc++;

  bit         mon_en = 1'b0;
  bit         mon_busy = 1'b0;
  int         mon_d = 1;
  int         mon_cnt = 0;
  logic [9:0] mon_bits;
  logic [8:0] rx_q[$];     // {framing ok, byte}
  int         start_q[$];

  always @(negedge clk) begin
    if (!mon_en) mon_busy = 1'b0;
    else begin
      if (!mon_busy) begin
        if (tx === 1'b0) begin
          mon_busy = 1'b1; mon_cnt = 0; start_q.push_back(cyc);
        end
      end else mon_cnt++;
      if (mon_busy) begin
        if (mon_cnt % mon_d == mon_d / 2) mon_bits[mon_cnt / mon_d] = tx;
        if (mon_cnt == 9 * mon_d + mon_d / 2) begin
          rx_q.push_back({~mon_bits[0] & mon_bits[9], mon_bits[8:1]});
          mon_busy = 1'b0;
        end
      end
    end
  end

  // Reference model: queue of capacity CAP, a frame occupies 10*D edges,
  // the head is taken whenever the line is free (or frees on this edge).
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  bit         m_busy, m_ovf;
  int         m_e, m_end, m_d;

  task automatic model_edge(input bit push, input logic [7:0] b, input bit clr);
    bit popn;
    popn = (m_q.size() > 0) && (!m_busy || m_e == m_end);
    if (m_busy && m_e == m_end) m_busy = 1'b0;
    if (popn) begin
      exp_q.push_back(m_q.pop_front());
      m_busy = 1'b1;
      m_end  = m_e + 10 * m_d;
    end
    if (push) begin
      if (m_q.size() < CAP) m_q.push_back(b);
      else m_ovf = 1'b1;
    end
    if (clr) m_ovf = 1'b0;
    m_e++;
  endtask

  function automatic logic [31:0] m_status();
    return {28'h0, m_q.size() == 0, m_ovf, m_q.size() == CAP, m_busy};
  endfunction

  function automatic logic frame_bit(input logic [7:0] b, input int f);
    if (f == 0) return 1'b0;
    if (f == 9) return 1'b1;
    return b[f-1];
  endfunction

  typedef struct packed {
    logic        s;
    logic        w;
    logic [3:0]  a;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;

  vec_t vt [13];

  initial begin
    logic [31:0] rd;
    logic        line_q[$];
    int          errs, t_end;
    bit          done;

    vt[0]  = '{1'b1, 1'b1, 4'h8, 32'h0000_0007, 32'h0};
    vt[1]  = '{1'b1, 1'b0, 4'h8, 32'h0,         32'h7};
    vt[2]  = '{1'b1, 1'b1, 4'h8, 32'h0,         32'h0};
    vt[3]  = '{1'b1, 1'b0, 4'h8, 32'h0,         32'h1};
    vt[4]  = '{1'b1, 1'b1, 4'h8, 32'hABCD_1234, 32'h0};
    vt[5]  = '{1'b1, 1'b0, 4'h8, 32'h0,         32'h1234};
    vt[6]  = '{1'b1, 1'b1, 4'hC, 32'hFFFF_FFFF, 32'h0};
    vt[7]  = '{1'b1, 1'b0, 4'hC, 32'h0,         32'h0};
    vt[8]  = '{1'b1, 1'b0, 4'h8, 32'h0,         32'h1234};
    vt[9]  = '{1'b1, 1'b0, 4'h0, 32'h0,         32'h0};
    vt[10] = '{1'b1, 1'b0, 4'h4, 32'h0,         32'h8};
    vt[11] = '{1'b0, 1'b0, 4'h4, 32'h0,         32'h0};
    vt[12] = '{1'b0, 1'b0, 4'h8, 32'h0,         32'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_irq", irq, 1);
    addr = UART_STATUS; #1;
    chk("rst_rdata_unsel", rdata, 0);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    load(UART_STATUS, rd);  chk("rst_status", rd, 32'h8);
    load(UART_BAUDDIV, rd); chk("rst_baud", rd, 434);
    @(posedge clk); #1;

    // Register table
    for (int i = 0; i < 13; i++) begin
      if (vt[i].s && vt[i].w) store(vt[i].a, vt[i].d);
      else begin
        sel = vt[i].s; we = 1'b0; addr = vt[i].a;
        #1 chk($sformatf("vec%0d", i), rdata, vt[i].e);
        sel = 1'b0;
        @(posedge clk); #1;
      end
    end

    // Single frame 0x55 at divider 4
    store(UART_BAUDDIV, 4);
    store(UART_TXDATA, 32'h55);
    chk("f55_tx_before_pop", tx, 1);
    load(UART_STATUS, rd);
    chk("f55_status_after_store", rd, (CAP == 1) ? 32'h2 : 32'h0);
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (tx !== frame_bit(8'h55, i / 4)) errs++;
      if (i == 39) chk("f55_irq_in_stop", irq, 0);
    end
    chk("f55_line", errs, 0);
    @(posedge clk); #1;
    chk("f55_irq_end", irq, 1);
    chk("f55_tx_end", tx, 1);

    // Divider change to 8 during data bit 3
    line_q.delete();
    for (int f = 0; f < 10; f++)
      for (int k = 0; k < ((f <= 4) ? 4 : 8); k++) line_q.push_back(frame_bit(8'hA5, f));
    store(UART_TXDATA, 32'hA5);
    errs = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (tx !== line_q[i]) errs++;
      if (i == 17) begin sel = 1'b1; we = 1'b1; addr = UART_BAUDDIV; wdata = 32'h8; end
      if (i == 18) begin sel = 1'b0; we = 1'b0; end
    end
    chk("baudchg_line", errs, 0);
    @(posedge clk); #1;
    chk("baudchg_irq_end", irq, 1);

    // Fill queue, overflow, clear, back-to-back frames at divider 2
    store(UART_BAUDDIV, 2);
    rx_q.delete(); start_q.delete(); mon_d = 2; mon_en = 1'b1;
    for (int i = 1; i <= CAP + 1; i++) store(UART_TXDATA, i);
    load(UART_STATUS, rd); chk("fill_status", rd, 32'h3);
    store(UART_TXDATA, 32'hEE);
    load(UART_STATUS, rd); chk("ovf_set", rd, 32'h7);
    store(UART_STATUS, 32'h4);
    load(UART_STATUS, rd); chk("ovf_clear", rd, 32'h3);
    done = 1'b0;
    for (int i = 0; i < 500 && !done; i++) begin
      @(posedge clk); #1;
      if (irq === 1'b1) done = 1'b1;
    end
    t_end = cyc;
    chk("b2b_timeout", done, 1);
    chk("b2b_frames", rx_q.size(), CAP + 1);
    if (start_q.size() > 0) chk("b2b_duration", t_end - start_q[0], (CAP + 1) * 20);
    for (int i = 0; i < rx_q.size(); i++) chk($sformatf("b2b_byte%0d", i), rx_q[i], {1'b1, 8'(i + 1)});
    mon_en = 1'b0;

    // Reset in the middle of a frame
    store(UART_BAUDDIV, 4);
    store(UART_TXDATA, 32'h00);
    store(UART_TXDATA, 32'h0F);
    repeat (12) @(posedge clk);
    #1 chk("mid_tx_low", tx, 0);
    #2 rst = 1'b0;
    #1 chk("mid_rst_tx", tx, 1);
    chk("mid_rst_irq", irq, 1);
    addr = UART_STATUS; #1 chk("mid_rst_unsel", rdata, 0);
    load(UART_STATUS, rd); chk("mid_rst_status", rd, 32'h8);
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    load(UART_BAUDDIV, rd); chk("mid_rst_baud", rd, 434);
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) errs++;
    end
    chk("mid_rst_no_resume", errs, 0);
    load(UART_STATUS, rd); chk("mid_rst_status_after", rd, 32'h8);
    @(posedge clk); #1;

    // Randomized traffic against the model
    for (int r = 0; r < 3; r++) begin
      int d, irq_err;
      d = $urandom_range(1, 3);
      store(UART_STATUS, 32'h4);
      store(UART_BAUDDIV, d);
      m_d = d; m_ovf = 1'b0; m_busy = 1'b0; m_e = 0; m_end = 0;
      m_q.delete(); exp_q.delete();
      mon_d = d; rx_q.delete(); start_q.delete(); mon_en = 1'b1;
      irq_err = 0; done = 1'b0;
      for (int i = 0; i < 1500 && !done; i++) begin
        bit         push, clr;
        logic [7:0] b;
        int         a;
        push = 1'b0; clr = 1'b0; b = 8'h0;
        if (irq !== ((m_q.size() == 0) && !m_busy)) irq_err++;
        if (i >= 300) begin
          if (m_q.size() == 0 && !m_busy) done = 1'b1;
        end else begin
          a = $urandom_range(0, 11);
          if (a < 2) begin
            wdata = $urandom; b = wdata[7:0];
            sel = 1'b1; we = 1'b1; addr = UART_TXDATA; push = 1'b1;
          end else if (a == 2) begin
            wdata = $urandom | 32'h4;
            sel = 1'b1; we = 1'b1; addr = UART_STATUS; clr = 1'b1;
          end else if (a < 6) begin
            load(UART_STATUS, rd);
            chk($sformatf("rand%0d_status_c%0d", r, i), rd, m_status());
          end
        end
        if (!done) begin
          @(posedge clk);
          model_edge(push, b, clr);
          #1 sel = 1'b0; we = 1'b0;
        end
      end
      chk($sformatf("rand%0d_drain_timeout", r), done, 1);
      @(posedge clk); #1;
      chk($sformatf("rand%0d_irq", r), irq_err, 0);
      chk($sformatf("rand%0d_frames", r), rx_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
        chk($sformatf("rand%0d_byte%0d", r, i), rx_q[i], {1'b1, exp_q[i]});
      load(UART_STATUS, rd);
      chk($sformatf("rand%0d_final_status", r), rd, m_status());
      mon_en = 1'b0;
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
